dehaze_frame_streamer: RTL and testbench

- Hardware pixel source for ALE_TE_Top. Reads a stored 24-bit BGR frame from a synchronous frame RAM and streams it twice: pass 1 feeds atmospheric-light estimation, then it waits for done_flag, raises en and replays the frame for transmission estimation.
- Replaces the bench-driven two-pass feed so the dehaze pipeline can run stand-alone on the FPGA.

---
 rtl/dehaze_pkg.sv | 34 +++
 rtl/dehaze_frame_streamer_fifo.sv | 57 +++++
 rtl/dehaze_frame_streamer.sv | 207 ++++++++++++++++++++
 tb/tb_dehaze_frame_streamer.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dehaze_pkg.sv
// dehaze_pkg: shared types and helpers for the dehaze frame streamer.
// Holds the FSM state encoding, pixel layout and frame-size helper.
package dehaze_pkg;

   localparam int PIX_W = 24;

   // Byte-lane offsets inside a stored BGR pixel word
   localparam int B_OFS = 0;
   localparam int G_OFS = 8;
   localparam int R_OFS = 16;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } pix_t;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_PASS1    = 3'd1,
      ST_DRAIN1   = 3'd2,
      ST_WAIT_ALE = 3'd3,
      ST_GAP      = 3'd4,
      ST_PASS2    = 3'd5,
      ST_DRAIN2   = 3'd6,
      ST_DONE     = 3'd7
   } dh_state_e;

   // Pixels per frame; rows are stored back to back with no padding
   function automatic int calc_npix(input int width, input int height);
      return width * height;
   endfunction

endpackage

// File: rtl/dehaze_frame_streamer_fifo.sv
// dehaze_pix_fifo2: 2-entry first-word-fall-through FIFO with occupancy count.
// The head entry is visible on o_dout whenever o_empty is low.
module dehaze_pix_fifo2
   import dehaze_pkg::*;
#(
   parameter int W = PIX_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_push,
   input  logic [W-1:0] i_din,
   input  logic         i_pop,
   output logic [W-1:0] o_dout,
   output logic         o_empty,
   output logic [1:0]   o_count
);

   logic [W-1:0] r_mem [2];
   logic         r_wr_ptr;
   logic         r_rd_ptr;
   logic [1:0]   r_count;
   logic         w_do_pop;
   logic         w_do_push;

   assign w_do_pop  = i_pop && (r_count != 2'd0);
   // A full FIFO still accepts a write when the head leaves in the same cycle
   assign w_do_push = i_push && ((r_count != 2'd2) || w_do_pop);

   assign o_dout  = r_mem[r_rd_ptr];
   assign o_empty = (r_count == 2'd0);
   assign o_count = r_count;

   // Storage, pointers and occupancy; push+pop together leaves the count alone
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_do_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/dehaze_frame_streamer.sv
// dehaze_frame_streamer: streams a stored BGR frame from frame RAM twice,
// first for atmospheric-light estimation, then (after done) for transmission
// estimation with te_en raised.
// Optional build macro ALE_TIMEOUT_EN adds a done-flag watchdog in WAIT_ALE
// that raises a sticky err_timeout and skips pass 2.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for start
// PASS1     | fetching frame for ALE, address 0..NPIX-1
// DRAIN1    | all pass-1 reads issued, emptying buffer
// WAIT_ALE  | waiting for ale_done (watchdog counts here if enabled)
// GAP       | te_en high, GAP_CYCLES settle before pass 2 fetch
// PASS2     | fetching frame again for TE
// DRAIN2    | all pass-2 reads issued, emptying buffer
// DONE      | one cycle, frame_done pulse
module dehaze_frame_streamer
   import dehaze_pkg::*;
#(
   parameter int IMG_WIDTH      = 512,
   parameter int IMG_HEIGHT     = 512,
   parameter int ADDR_W         = 18,
   parameter int PIX_W          = 24,
   parameter int GAP_CYCLES     = 2,
   parameter int TIMEOUT_CYCLES = 2000000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [PIX_W-1:0]  mem_rdata,
   output logic [PIX_W-1:0]  pixel_out,
   output logic              pixel_valid,
   input  logic              pixel_ready,
   input  logic              ale_done,
   output logic              te_en,
   output logic              busy,
   output logic              pass_id,
   output logic              frame_done,
   output logic              err_timeout
);

   localparam int NPIX = calc_npix(IMG_WIDTH, IMG_HEIGHT);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
   localparam int GAP_W = $clog2(GAP_CYCLES + 1);
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

   localparam logic [2:0] S_IDLE     = 3'(ST_IDLE);
   localparam logic [2:0] S_PASS1    = 3'(ST_PASS1);
   localparam logic [2:0] S_DRAIN1   = 3'(ST_DRAIN1);
   localparam logic [2:0] S_WAIT_ALE = 3'(ST_WAIT_ALE);
   localparam logic [2:0] S_GAP      = 3'(ST_GAP);
   localparam logic [2:0] S_PASS2    = 3'(ST_PASS2);
   localparam logic [2:0] S_DRAIN2   = 3'(ST_DRAIN2);
   localparam logic [2:0] S_DONE     = 3'(ST_DONE);

   logic [2:0]        r_state;
   logic [ADDR_W-1:0] r_addr;
   logic              r_inflight;
   logic [GAP_W-1:0]  r_gap_cnt;
   logic              r_te_en;
   logic              r_pass_id;

   logic              w_fetching;
   logic              w_pop;
   logic              w_empty;
   logic [1:0]        w_count;
   logic [2:0]        w_occ_after;
   logic              w_issue;
   logic              w_to_hit;
   logic              w_err;

   // Occupancy is judged after this cycle's pop so a steady 1 pixel/cycle
   // stream keeps exactly one word buffered and one read in flight.
   assign w_fetching  = (r_state == S_PASS1) || (r_state == S_PASS2);
   assign w_pop       = !w_empty && pixel_ready;
   assign w_occ_after = 3'(w_count) - 3'(w_pop) + 3'(r_inflight);
   assign w_issue     = w_fetching && (w_occ_after < 3'd2);

   assign mem_rd_en   = w_issue;
   assign mem_addr    = r_addr;
   assign pixel_valid = !w_empty;
   assign te_en       = r_te_en;
   assign busy        = (r_state != S_IDLE);
   assign pass_id     = r_pass_id;
   assign frame_done  = (r_state == S_DONE);
   assign err_timeout = w_err;

   dehaze_pix_fifo2 #(
      .W(PIX_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (r_inflight),
      .i_din   (mem_rdata),
      .i_pop   (w_pop),
      .o_dout  (pixel_out),
      .o_empty (w_empty),
      .o_count (w_count)
   );

`ifdef ALE_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);

   logic [TO_W-1:0] r_to_cnt;
   logic            r_err;

   assign w_to_hit = (r_state == S_WAIT_ALE) && (r_to_cnt == '0) && !ale_done;
   assign w_err    = r_err;

   // Watchdog: reloads outside WAIT_ALE, counts down inside; error is sticky
   always_ff @(posedge clk) begin
      if (rst) begin
         r_to_cnt <= '0;
         r_err    <= 1'b0;
      end else begin
         if (r_state != S_WAIT_ALE) begin
            r_to_cnt <= TO_LOAD;
         end else if (r_to_cnt != '0) begin
            r_to_cnt <= r_to_cnt - TO_W'(1);
         end
         if (w_to_hit) begin
            r_err <= 1'b1;
         end
      end
   end
`else
   // Never true; WAIT_ALE waits for ale_done indefinitely. The expression
   // keeps the watchdog limit parameter referenced in this build.
   assign w_to_hit = (TIMEOUT_CYCLES < 0);
   assign w_err    = 1'b0;
`endif

   // Sequencer: state, read address, in-flight tracking and pass controls
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_addr     <= '0;
         r_inflight <= 1'b0;
         r_gap_cnt  <= '0;
         r_te_en    <= 1'b0;
         r_pass_id  <= 1'b0;
      end else begin
         r_inflight <= w_issue;
         if (w_issue) begin
            r_addr <= r_addr + ADDR_W'(1);
         end
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state <= S_PASS1;
                  r_addr  <= '0;
               end
            end
            S_PASS1: begin
               if (w_issue && (r_addr == LAST_ADDR)) begin
                  r_state <= S_DRAIN1;
               end
            end
            S_DRAIN1: begin
               if (w_empty && !r_inflight) begin
                  r_state <= S_WAIT_ALE;
               end
            end
            S_WAIT_ALE: begin
               if (ale_done) begin
                  r_state   <= S_GAP;
                  r_te_en   <= 1'b1;
                  r_pass_id <= 1'b1;
                  r_addr    <= '0;
                  r_gap_cnt <= GAP_LOAD;
               end else if (w_to_hit) begin
                  r_state <= S_DONE;
               end
            end
            S_GAP: begin
               if (r_gap_cnt == '0) begin
                  r_state <= S_PASS2;
               end else begin
                  r_gap_cnt <= r_gap_cnt - GAP_W'(1);
               end
            end
            S_PASS2: begin
               if (w_issue && (r_addr == LAST_ADDR)) begin
                  r_state <= S_DRAIN2;
               end
            end
            S_DRAIN2: begin
               if (w_empty && !r_inflight) begin
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_state   <= S_IDLE;
               r_te_en   <= 1'b0;
               r_pass_id <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dehaze_frame_streamer.sv
// tb_dehaze_frame_streamer: randomized self-checking bench for the
// two-pass frame streamer on a 4x2 frame. Define ALE_TIMEOUT_EN to also
// exercise the watchdog path.
module tb_dehaze_frame_streamer;

   localparam int NPIX = 8;
   localparam int GAP  = 2;
   localparam int TO   = 20;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        mem_rd_en;
   logic [17:0] mem_addr;
   logic [23:0] mem_rdata = '0;
   logic [23:0] pixel_out;
   logic        pixel_valid;
   logic        pixel_ready = 1'b0;
   logic        ale_done = 1'b0;
   logic        te_en;
   logic        busy;
   logic        pass_id;
   logic        frame_done;
   logic        err_timeout;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int rdy_mode = 0;

   // Observed transfer log and event times, all kept by the monitor
   logic [23:0] xq[$];
   bit          xp[$];
   int          xc[$];
   int          iss = 0;
   int          te_rise = -1;
   int          fd_cnt = 0;
   int          fd_cyc = -1;
   int          busy_fall = -1;
   bit          ovf_err = 0;
   bit          stall_err = 0;

   dehaze_frame_streamer #(
      .IMG_WIDTH(4), .IMG_HEIGHT(2), .ADDR_W(18), .PIX_W(24),
      .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .pixel_out(pixel_out), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
      .ale_done(ale_done), .te_en(te_en), .busy(busy), .pass_id(pass_id),
      .frame_done(frame_done), .err_timeout(err_timeout)
   );

   initial forever #5 clk = ~clk;

   function automatic logic [23:0] word(input int n);
      logic [23:0] v;
      v = 24'(n) * 24'h010000 + 24'(n);
      return v;
   endfunction

   // Synchronous frame RAM: data valid one cycle after the strobe, else X
   always @(posedge clk) begin
      if (mem_rd_en) mem_rdata <= word(int'(mem_addr));
      else           mem_rdata <= 'x;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Downstream ready pattern: 0 hold high, 1 random, 2 toggle, 3 stall
   initial forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
         0:       pixel_ready = 1'b1;
         1:       pixel_ready = 1'($urandom_range(0, 1));
         2:       pixel_ready = ~pixel_ready;
         default: pixel_ready = 1'b0;
      endcase
   end

   // Monitor: logs transfers/events and flags buffering or stall violations
   initial begin
      bit          xfer;
      bit          prev_stall = 0;
      logic [23:0] prev_pix = '0;
      bit          te_prev = 0;
      bit          busy_prev = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            xq.delete(); xp.delete(); xc.delete();
            iss = 0; te_rise = -1; fd_cnt = 0; fd_cyc = -1; busy_fall = -1;
            prev_stall = 0; te_prev = 0; busy_prev = 0;
         end else begin
            xfer = pixel_valid && pixel_ready;
            if ((iss + int'(mem_rd_en)) - (xq.size() + int'(xfer)) > 2) ovf_err = 1;
            if (prev_stall && (!pixel_valid || pixel_out !== prev_pix)) stall_err = 1;
            prev_stall = pixel_valid && !pixel_ready;
            prev_pix   = pixel_out;
            if (xfer) begin
               xq.push_back(pixel_out); xp.push_back(pass_id); xc.push_back(cyc);
            end
            if (mem_rd_en) iss++;
            if (te_en && !te_prev && te_rise < 0) te_rise = cyc;
            if (frame_done) begin fd_cnt++; fd_cyc = cyc; end
            if (busy_prev && !busy) busy_fall = cyc;
            te_prev   = te_en;
            busy_prev = busy;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      ovf_err = 0;
      stall_err = 0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic wait_xfers(input int n, input int budget, output bit ok);
      int k = 0;
      while (xq.size() < n && k < budget) begin tick(1); k++; end
      ok = (xq.size() >= n);
   endtask

   task automatic wait_cyc(input int target, output bit ok);
      ok = (cyc <= target);
      while (cyc < target) tick(1);
   endtask

   task automatic wait_fd(input int budget, output bit ok);
      int k = 0;
      while (fd_cnt == 0 && k < budget) begin tick(1); k++; end
      ok = (fd_cnt > 0);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(2);
      checks++;
      if ({mem_rd_en, mem_addr, pixel_out, pixel_valid, te_en, busy, pass_id,
           frame_done, err_timeout} !== '0) begin
         failures++;
         $display("FAIL reset_outputs rd=%b addr=%h pix=%h v=%b te=%b busy=%b pid=%b fd=%b err=%b required all 0",
                  mem_rd_en, mem_addr, pixel_out, pixel_valid, te_en, busy, pass_id, frame_done, err_timeout);
      end
      rst = 1'b0;
      tick(3);
      checks++;
      if (busy !== 1'b0 || pixel_valid !== 1'b0) begin
         failures++;
         $display("FAIL idle_no_start busy=%b valid=%b required 0/0", busy, pixel_valid);
      end
   endtask

   task automatic test_basic();
      bit ok;
      int w;
      do_reset();
      rdy_mode = 0;
      tick(1);
      pulse_start();
      wait_xfers(NPIX, 60, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL basic_pass1_wait got %0d xfers required %0d", xq.size(), NPIX); end
      w = xc[NPIX-1] + 2;
      wait_cyc(w + 5, ok);
      ale_done = 1'b1;
      tick(1);
      ale_done = 1'b0;
      wait_xfers(2*NPIX, 80, ok);
      tick(6);
      checks++;
      if (!ok || xq.size() != 2*NPIX) begin
         failures++; $display("FAIL basic_count got %0d required %0d", xq.size(), 2*NPIX);
      end else begin
         for (int i = 0; i < 2*NPIX; i++) begin
            checks++;
            if (xq[i] !== word(i % NPIX) || xp[i] !== bit'(i >= NPIX)) begin
               failures++;
               $display("FAIL basic_data[%0d] got %h/%0d required %h/%0d", i, xq[i], xp[i], word(i % NPIX), i >= NPIX);
            end
         end
         checks++;
         if (xc[NPIX-1] != xc[0] + NPIX-1 || xc[2*NPIX-1] != xc[NPIX] + NPIX-1) begin
            failures++; $display("FAIL basic_back_to_back spans %0d,%0d required %0d", xc[NPIX-1]-xc[0], xc[2*NPIX-1]-xc[NPIX], NPIX-1);
         end
         checks++;
         if (te_rise != w + 6) begin failures++; $display("FAIL basic_te_rise got %0d required %0d", te_rise, w + 6); end
         checks++;
         if (xc[NPIX] != te_rise + GAP + 2) begin failures++; $display("FAIL basic_gap got %0d required %0d", xc[NPIX], te_rise + GAP + 2); end
         checks++;
         if (fd_cnt != 1 || fd_cyc != xc[2*NPIX-1] + 2) begin
            failures++; $display("FAIL basic_frame_done cnt=%0d cyc=%0d required 1/%0d", fd_cnt, fd_cyc, xc[2*NPIX-1] + 2);
         end
         checks++;
         if (busy_fall != xc[2*NPIX-1] + 3 || te_en !== 1'b0 || pass_id !== 1'b0) begin
            failures++; $display("FAIL basic_end busy_fall=%0d te=%b pid=%b required %0d/0/0", busy_fall, te_en, pass_id, xc[2*NPIX-1] + 3);
         end
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      int w;
      do_reset();
      rdy_mode = 2;
      pulse_start();
      wait_xfers(2, 60, ok);
      ale_done = 1'b1;
      tick(1);
      ale_done = 1'b0;
      wait_xfers(4, 60, ok);
      rdy_mode = 3;
      tick(6);
      rdy_mode = 1;
      wait_xfers(NPIX, 120, ok);
      checks++;
      if (!ok || te_rise != -1) begin failures++; $display("FAIL bp_pass1 xfers=%0d te_rise=%0d required %0d/-1", xq.size(), te_rise, NPIX); end
      w = xc[NPIX-1] + 2;
      wait_cyc(w + 3, ok);
      ale_done = 1'b1;
      tick(1);
      ale_done = 1'b0;
      wait_xfers(2*NPIX, 200, ok);
      tick(6);
      checks++;
      if (te_rise != w + 4) begin failures++; $display("FAIL bp_te_rise got %0d required %0d", te_rise, w + 4); end
      checks++;
      if (xq.size() != 2*NPIX || fd_cnt != 1) begin
         failures++; $display("FAIL bp_count got %0d fd=%0d required %0d/1", xq.size(), fd_cnt, 2*NPIX);
      end else begin
         for (int i = 0; i < 2*NPIX; i++) begin
            checks++;
            if (xq[i] !== word(i % NPIX) || xp[i] !== bit'(i >= NPIX)) begin
               failures++;
               $display("FAIL bp_data[%0d] got %h/%0d required %h/%0d", i, xq[i], xp[i], word(i % NPIX), i >= NPIX);
            end
         end
      end
      checks++;
      if (ovf_err !== 1'b0) begin failures++; $display("FAIL bp_outstanding got >2 required <=2"); end
      checks++;
      if (stall_err !== 1'b0) begin failures++; $display("FAIL bp_stall_stable got changed required stable"); end
   endtask

   task automatic test_ale_early();
      bit ok;
      do_reset();
      rdy_mode = 1;
      ale_done = 1'b1;
      pulse_start();
      wait_xfers(NPIX, 120, ok);
      tick(6);
      checks++;
      if (!ok || te_rise != xc[NPIX-1] + 3) begin
         failures++; $display("FAIL early_te_rise got %0d required %0d", te_rise, xc[NPIX-1] + 3);
      end
      ale_done = 1'b0;
      wait_xfers(2*NPIX, 200, ok);
      tick(6);
      checks++;
      if (xq.size() != 2*NPIX || fd_cnt != 1 || busy !== 1'b0) begin
         failures++; $display("FAIL early_complete xfers=%0d fd=%0d busy=%b required %0d/1/0", xq.size(), fd_cnt, busy, 2*NPIX);
      end else begin
         for (int i = 0; i < 2*NPIX; i++) begin
            checks++;
            if (xq[i] !== word(i % NPIX) || xp[i] !== bit'(i >= NPIX)) begin
               failures++;
               $display("FAIL early_data[%0d] got %h/%0d required %h/%0d", i, xq[i], xp[i], word(i % NPIX), i >= NPIX);
            end
         end
      end
   endtask

   task automatic test_rst_midrun();
      bit ok;
      do_reset();
      rdy_mode = 0;
      ale_done = 1'b1;
      pulse_start();
      wait_xfers(NPIX + 3, 80, ok);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      checks++;
      if ({mem_rd_en, mem_addr, pixel_out, pixel_valid, te_en, busy, pass_id,
           frame_done, err_timeout} !== '0) begin
         failures++;
         $display("FAIL rst_mid_outputs rd=%b addr=%h pix=%h v=%b te=%b busy=%b pid=%b fd=%b required all 0",
                  mem_rd_en, mem_addr, pixel_out, pixel_valid, te_en, busy, pass_id, frame_done);
      end
      rdy_mode = 1;
      tick(2);
      pulse_start();
      wait_xfers(2*NPIX, 200, ok);
      tick(6);
      checks++;
      if (xq.size() != 2*NPIX || fd_cnt != 1) begin
         failures++; $display("FAIL rst_replay_count got %0d fd=%0d required %0d/1", xq.size(), fd_cnt, 2*NPIX);
      end else begin
         for (int i = 0; i < 2*NPIX; i++) begin
            checks++;
            if (xq[i] !== word(i % NPIX) || xp[i] !== bit'(i >= NPIX)) begin
               failures++;
               $display("FAIL rst_replay_data[%0d] got %h/%0d required %h/%0d", i, xq[i], xp[i], word(i % NPIX), i >= NPIX);
            end
         end
      end
      ale_done = 1'b0;
   endtask

   task automatic test_start_ignored();
      bit ok;
      do_reset();
      rdy_mode = 0;
      ale_done = 1'b1;
      pulse_start();
      wait_xfers(NPIX + 2, 80, ok);
      pulse_start();
      wait_xfers(2*NPIX, 80, ok);
      tick(12);
      checks++;
      if (xq.size() != 2*NPIX || fd_cnt != 1 || busy !== 1'b0) begin
         failures++; $display("FAIL start_ignored xfers=%0d fd=%0d busy=%b required %0d/1/0", xq.size(), fd_cnt, busy, 2*NPIX);
      end else begin
         for (int i = 0; i < 2*NPIX; i++) begin
            checks++;
            if (xq[i] !== word(i % NPIX) || xp[i] !== bit'(i >= NPIX)) begin
               failures++;
               $display("FAIL start_ign_data[%0d] got %h/%0d required %h/%0d", i, xq[i], xp[i], word(i % NPIX), i >= NPIX);
            end
         end
      end
      ale_done = 1'b0;
   endtask

`ifdef ALE_TIMEOUT_EN
   task automatic test_timeout();
      bit ok;
      int w;
      do_reset();
      rdy_mode = 0;
      ale_done = 1'b0;
      pulse_start();
      wait_xfers(NPIX, 60, ok);
      w = xc[NPIX-1] + 2;
      wait_fd(80, ok);
      tick(5);
      checks++;
      if (!ok || fd_cyc != w + TO || fd_cnt != 1) begin
         failures++; $display("FAIL timeout_frame_done cyc=%0d cnt=%0d required %0d/1", fd_cyc, fd_cnt, w + TO);
      end
      checks++;
      if (err_timeout !== 1'b1 || busy !== 1'b0) begin
         failures++; $display("FAIL timeout_err err=%b busy=%b required 1/0", err_timeout, busy);
      end
      checks++;
      if (xq.size() != NPIX || te_rise != -1) begin
         failures++; $display("FAIL timeout_no_pass2 xfers=%0d te_rise=%0d required %0d/-1", xq.size(), te_rise, NPIX);
      end
      do_reset();
      checks++;
      if (err_timeout !== 1'b0) begin failures++; $display("FAIL timeout_clear got %b required 0", err_timeout); end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_ale_early();
      test_rst_midrun();
      test_start_ignored();
`ifdef ALE_TIMEOUT_EN
      test_timeout();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout time limit reached required completion");
      $fatal(1, "bench time limit");
   end

endmodule
